// File: rtl/ftdi_axis_byte_fifo_if.sv
// Byte-stream handshake bundle (data, dest, id, valid/ready) used on both
// sides of ftdi_axis_byte_fifo.
interface ftdi_axis_byte_fifo_if #(
  parameter int DEST_WIDTH = 8,
  parameter int ID_WIDTH   = 8
);
  logic [7:0]            tdata;
  logic                  tvalid;
  logic                  tready;
  logic [DEST_WIDTH-1:0] tdest;
  logic [ID_WIDTH-1:0]   tid;

  modport master (output tdata, output tvalid, output tdest, output tid, input tready);
  modport slave  (input tdata, input tvalid, input tdest, input tid, output tready);
endinterface

// File: rtl/ftdi_axis_byte_fifo.sv
// First-word-fall-through byte FIFO with sticky overflow and registered
// almost flags. Define FTDI_FIFO_DROP_COUNTER_EN to add a saturating drop_count.
module ftdi_axis_byte_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int AF_MARGIN  = 8,
  parameter int AE_MARGIN  = 4,
  parameter int DEST_WIDTH = 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  res,
  ftdi_axis_byte_fifo_if.slave  s_axis,
  ftdi_axis_byte_fifo_if.master m_axis,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  overflow_clr
`ifdef FTDI_FIFO_DROP_COUNTER_EN
  ,
  output logic [15:0]           drop_count
`endif
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] AE_LEVEL = CNT_W'(AE_MARGIN);

  typedef struct packed {
    logic [7:0]            data;
    logic [DEST_WIDTH-1:0] dest;
    logic [ID_WIDTH-1:0]   id;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           wr_entry;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             overflow_q, overflow_d;

  logic             full, empty;
  logic             wr, rd, drop;

  // A write into a full FIFO still lands if the head leaves in the same cycle;
  // the upstream bridge never looks at tready, so a true drop is recorded.
  always_comb begin
    full  = (count_q == CNT_FULL);
    empty = (count_q == '0);
    rd    = ~empty & m_axis.tready;
    wr    = s_axis.tvalid & (~full | rd);
    drop  = s_axis.tvalid & full & ~rd;
  end

  assign wr_entry = '{data: s_axis.tdata, dest: s_axis.tdest, id: s_axis.tid};

  // NOTE: every signal gets its default before any branch, so no path through
  // the block leaves a value held and no latch is inferred.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (wr) wptr_d = wptr_q + PTR_W'(1);
    if (rd) rptr_d = rptr_q + PTR_W'(1);

    unique case ({wr, rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;

    almost_full_d  = (count_d >= AF_LEVEL);
    almost_empty_d = (count_d <= AE_LEVEL);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; res is only looked at on the clock edge (synchronous).
  always_ff @(posedge clk) begin
    if (res) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because count gates m_axis_tvalid, and a reset would block RAM mapping.
  always_ff @(posedge clk) begin
    if (wr && !res) mem_q[wptr_q] <= wr_entry;
  end

`ifdef FTDI_FIFO_DROP_COUNTER_EN
  logic [15:0] drop_count_q, drop_count_d;

  // A drop coinciding with a clear leaves exactly that one drop counted.
  always_comb begin
    drop_count_d = drop_count_q;
    if (overflow_clr)                          drop_count_d = drop ? 16'd1 : 16'd0;
    else if (drop && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (res) drop_count_q <= '0;
    else     drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`endif

  assign s_axis.tready = ~full;
  assign m_axis.tvalid = ~empty;
  assign m_axis.tdata  = mem_q[rptr_q].data;
  assign m_axis.tdest  = mem_q[rptr_q].dest;
  assign m_axis.tid    = mem_q[rptr_q].id;

  assign count         = count_q;
  assign almost_full   = almost_full_q;
  assign almost_empty  = almost_empty_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_ftdi_axis_byte_fifo.sv
// Randomised scoreboard bench for ftdi_axis_byte_fifo: a queue model predicts
// accepted entries, a negedge monitor checks every byte leaving the FIFO.
module tb_ftdi_axis_byte_fifo;
  localparam int DEPTH_LOG2 = 9;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int AF_MARGIN  = 8;
  localparam int AE_MARGIN  = 4;

  logic clk = 1'b0;
  logic res;
  logic overflow_clr;
  logic almost_full, almost_empty, overflow;
  logic [DEPTH_LOG2:0] count;
`ifdef FTDI_FIFO_DROP_COUNTER_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  ftdi_axis_byte_fifo_if #(.DEST_WIDTH(8), .ID_WIDTH(8)) s_if ();
  ftdi_axis_byte_fifo_if #(.DEST_WIDTH(8), .ID_WIDTH(8)) m_if ();

  ftdi_axis_byte_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2), .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN),
    .DEST_WIDTH(8), .ID_WIDTH(8)
  ) dut (
    .clk          (clk),
    .res          (res),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
`ifdef FTDI_FIFO_DROP_COUNTER_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] dest;
    logic [7:0] id;
  } ent_t;

  ent_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   m_count = 0;
  bit   m_ovf   = 1'b0;
  int   m_drops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_state();
    check("count",         32'(count),         32'(m_count));
    check("m_tvalid",      32'(m_if.tvalid),   32'(m_count > 0));
    check("s_tready",      32'(s_if.tready),   32'(m_count < DEPTH));
    check("almost_full",   32'(almost_full),   32'(m_count >= DEPTH - AF_MARGIN));
    check("almost_empty",  32'(almost_empty),  32'(m_count <= AE_MARGIN));
    check("overflow",      32'(overflow),      32'(m_ovf));
`ifdef FTDI_FIFO_DROP_COUNTER_EN
    check("drop_count",    32'(drop_count),    32'(m_drops));
`endif
  endtask

  task automatic check_head();
    if (exp_q.size() > 0) begin
      check("head_data", 32'(m_if.tdata), 32'(exp_q[0].data));
      check("head_dest", 32'(m_if.tdest), 32'(exp_q[0].dest));
      check("head_id",   32'(m_if.tid),   32'(exp_q[0].id));
    end
  endtask

  // One clock cycle: drive inputs, advance the model, then check after the edge.
  task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit clr,
                      output bit accepted);
    ent_t e;
    bit   rd_m, wr_m, drop_m;
    e.data = d;
    e.dest = 8'($urandom);
    e.id   = 8'($urandom);
    s_if.tvalid  = v;
    s_if.tdata   = d;
    s_if.tdest   = e.dest;
    s_if.tid     = e.id;
    m_if.tready  = rdy;
    overflow_clr = clr;

    rd_m   = (m_count > 0) && rdy;
    wr_m   = v && ((m_count < DEPTH) || rd_m);
    drop_m = v && !wr_m;
    if (wr_m) exp_q.push_back(e);
    m_count = m_count + int'(wr_m) - int'(rd_m);
    if (drop_m)   m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (clr)                           m_drops = drop_m ? 1 : 0;
    else if (drop_m && m_drops < 65535) m_drops++;
    accepted = wr_m;

    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    res          = 1'b1;
    s_if.tvalid  = 1'b1;
    s_if.tdata   = 8'hEE;
    s_if.tdest   = 8'h00;
    s_if.tid     = 8'h00;
    m_if.tready  = 1'b0;
    overflow_clr = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
    @(posedge clk);
    #1;
    res         = 1'b0;
    s_if.tvalid = 1'b0;
    check_state();
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 2 * DEPTH && m_count > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check("drained_count", 32'(count), 32'(0));
  endtask

  // Monitor: the inputs are stable at negedge, so a handshake visible here is
  // the read the next rising edge performs.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!res && m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_read: got 0x%0h, expected no data (t=%0t)", m_if.tdata, $time);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 32'(m_if.tdata), 32'(e.data));
          check("rd_dest", 32'(m_if.tdest), 32'(e.dest));
          check("rd_id",   32'(m_if.tid),   32'(e.id));
        end
      end
    end
  end

  initial begin
    bit acc;
    int writes;
    int cyc;
    int rdy_pct;

    do_reset();

    // Three writes with the sink stalled: FWFT head and low occupancy flags.
    step(1'b1, 8'h11, 1'b0, 1'b0, acc);
    step(1'b1, 8'h22, 1'b0, 1'b0, acc);
    step(1'b1, 8'h33, 1'b0, 1'b0, acc);
    check_head();
    drain();

    // Five writes then a drain: ordering preserved, tready never drops.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, acc);
    check_head();
    drain();

    // Fill to the brim, then one write too many.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, acc);
    check_head();
    step(1'b1, 8'hAA, 1'b0, 1'b0, acc);
    check("drop_not_accepted", 32'(acc), 32'(0));
    // Drop and clear together: set wins.
    step(1'b1, 8'hBB, 1'b0, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);

    // Write and read together while full: nothing is lost.
    step(1'b1, 8'h5A, 1'b1, 1'b0, acc);
    check_head();
    drain();

    // Random traffic in blocks of light and heavy draining, crossing many wraps.
    writes = 0;
    cyc    = 0;
    rdy_pct = 50;
    while (writes < 2000 && cyc < 20000) begin
      if (cyc % 256 == 0) rdy_pct = ($urandom_range(0, 1) == 0) ? 20 : 90;
      step($urandom_range(0, 99) < 70, 8'($urandom),
           $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 63) == 0, acc);
      if (acc) writes++;
      cyc++;
    end
    check("random_writes_done", 32'(writes), 32'(2000));
    drain();

    // Reset in the middle of a stream holding 100 entries.
    for (int i = 0; i < 100; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, acc);
    do_reset();
    step(1'b1, 8'h77, 1'b0, 1'b0, acc);
    check_head();
    drain();
    step(1'b0, 8'h00, 1'b0, 1'b0, acc);

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
